// File: rtl/t07_fsm_grid_cursor_pkg.sv
// Shared definitions for the grid cursor: one-hot button codes, game/playing
// state encodings, hold FSM states and a width helper.
package t07_fsm_grid_cursor_pkg;

  localparam logic [5:0] BTN_NONE   = 6'b000000;
  localparam logic [5:0] BTN_SELECT = 6'b000001;
  localparam logic [5:0] BTN_UP     = 6'b000010;
  localparam logic [5:0] BTN_RIGHT  = 6'b000100;
  localparam logic [5:0] BTN_DOWN   = 6'b001000;
  localparam logic [5:0] BTN_LEFT   = 6'b010000;
  localparam logic [5:0] BTN_BACK   = 6'b100000;

  // Bit positions in step_req (button[4:1] shifted down by one)
  localparam int STEP_UP    = 0;
  localparam int STEP_RIGHT = 1;
  localparam int STEP_DOWN  = 2;
  localparam int STEP_LEFT  = 3;

  typedef enum logic [2:0] {
    GS_MENU = 3'b000,
    GS_PLAY = 3'b001,
    GS_LOST = 3'b010,
    GS_WON  = 3'b011
  } game_state_t;

  typedef enum logic [2:0] {
    PS_MOD  = 3'b000,
    PS_MAZE = 3'b001
  } playing_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_DELAY,
    HS_REPEAT
  } hold_state_t;

  // Bits needed to hold 0..n-1, never less than one
  function automatic int width_of(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/t07_fsm_grid_cursor_if.sv
// Cursor bus: strobe/state/button inputs towards the locator and the
// cursor position plus event pulses back out.
//   master: button/strobe source side (drives inputs, reads cursor)
//   slave : the cursor locator
interface t07_fsm_grid_cursor_if
  import t07_fsm_grid_cursor_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 2
);

  localparam int RW = width_of(ROWS);
  localparam int CW = width_of(COLS);
  localparam int IW = width_of(ROWS * COLS);

  logic          strobe;
  logic [2:0]    game_state_in;
  logic [2:0]    playing_state_in;
  logic [5:0]    button;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic [IW-1:0] cur_index;
  logic          moved;
  logic          select_pulse;
  logic          back_pulse;

  modport master (
    output strobe, game_state_in, playing_state_in, button,
    input  cur_row, cur_col, cur_index, moved, select_pulse, back_pulse
  );

  modport slave (
    input  strobe, game_state_in, playing_state_in, button,
    output cur_row, cur_col, cur_index, moved, select_pulse, back_pulse
  );

endinterface

// File: rtl/t07_fsm_grid_cursor_button_repeat.sv
// Button press-edge detector with hold-to-auto-repeat.
//   clk, rst   : clock, asynchronous active-high reset
//   strobe     : sample enable for button
//   active     : cursor responds; when low the hold FSM is parked in IDLE
//   button     : one-hot button bus (non one-hot reads as no press)
//   step_req   : {LEFT,DOWN,RIGHT,UP} step request, valid during the strobe cycle
//   sel_edge   : SELECT press edge, valid during the strobe cycle
//   back_edge  : BACK press edge, valid during the strobe cycle
module t07_fsm_grid_cursor_button_repeat
  import t07_fsm_grid_cursor_pkg::*;
#(
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic       active,
  input  logic [5:0] button,
  output logic [3:0] step_req,
  output logic       sel_edge,
  output logic       back_edge
);

  localparam int CNTW = width_of((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE);
  localparam logic [CNTW-1:0] DLY_LAST  = CNTW'(REPEAT_DLY - 1);
  localparam logic [CNTW-1:0] RATE_LAST = CNTW'(REPEAT_RATE - 1);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

  hold_state_t     state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [5:0]      prev_q, prev_d;
  logic [5:0]      vbtn;
  logic            is_dir;
  logic            press;
  logic            step;

  always_comb begin
    vbtn      = $onehot(button) ? button : BTN_NONE;
    is_dir    = |vbtn[4:1];
    press     = strobe && (vbtn != prev_q) && (vbtn != BTN_NONE);
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_d    = strobe ? vbtn : prev_q;
    step      = 1'b0;
    sel_edge  = 1'b0;
    back_edge = 1'b0;

    if (!active) begin
      state_d = HS_IDLE;
      cnt_d   = '0;
    end else if (strobe) begin
      // A fresh press is handled identically from any state, which gives the
      // immediate step + timer restart when switching direction mid-hold.
      if (press) begin
        cnt_d = '0;
        if (is_dir) begin
          step    = 1'b1;
          state_d = HS_DELAY;
        end else begin
          state_d   = HS_IDLE;
          sel_edge  = (vbtn == BTN_SELECT);
          back_edge = (vbtn == BTN_BACK);
        end
      end else if (vbtn == BTN_NONE) begin
        state_d = HS_IDLE;
        cnt_d   = '0;
      end else begin
        // Same valid button still held
        case (state_q)
          HS_DELAY: begin
            if (cnt_q == DLY_LAST) begin
              step    = 1'b1;
              cnt_d   = '0;
              state_d = HS_REPEAT;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          HS_REPEAT: begin
            if (cnt_q == RATE_LAST) begin
              step  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end

    step_req = step ? vbtn[4:1] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HS_IDLE;
      cnt_q   <= '0;
      prev_q  <= BTN_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end

endmodule

// File: rtl/t07_fsm_grid_cursor.sv
// ROWS x COLS grid cursor locator driven by a strobed one-hot button bus.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : slave side of the cursor bus (strobe, game/playing state, button in;
//         cur_row/cur_col/cur_index, moved, select_pulse, back_pulse out)
// All outputs are registered and appear the cycle after the strobe.
module t07_fsm_grid_cursor
  import t07_fsm_grid_cursor_pkg::*;
#(
  parameter int         ROWS          = 2,
  parameter int         COLS          = 2,
  parameter int         WRAP          = 0,
  parameter logic [2:0] ACTIVE_PSTATE = 3'b000,
  parameter int         REPEAT_DLY    = 8,
  parameter int         REPEAT_RATE   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  t07_fsm_grid_cursor_if.slave  bus
);

  localparam int RW = width_of(ROWS);
  localparam int CW = width_of(COLS);
  localparam int IW = width_of(ROWS * COLS);

  localparam logic [RW:0] ROW_MAX = (RW + 1)'(ROWS - 1);
  localparam logic [CW:0] COL_MAX = (CW + 1)'(COLS - 1);
  localparam logic [RW:0] ROW_ONE = (RW + 1)'(1);
  localparam logic [CW:0] COL_ONE = (CW + 1)'(1);

  logic          menu;
  logic          active;
  logic [3:0]    step_req;
  logic          sel_edge;
  logic          back_edge;

  logic [RW:0]   row_x;
  logic [CW:0]   col_x;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          moved_d;
  logic          moved_q, sel_q, back_q;

  assign menu   = (bus.game_state_in == GS_MENU);
  assign active = (bus.game_state_in == GS_PLAY) && (bus.playing_state_in == ACTIVE_PSTATE);

  t07_fsm_grid_cursor_button_repeat #(
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_repeat (
    .clk       (clk),
    .rst       (rst),
    .strobe    (bus.strobe),
    .active    (active),
    .button    (bus.button),
    .step_req  (step_req),
    .sel_edge  (sel_edge),
    .back_edge (back_edge)
  );

  // Grid arithmetic is done one bit wider than the position so the edge
  // compares never see a wrapped-around intermediate value.
  always_comb begin
    row_x = {1'b0, row_q};
    col_x = {1'b0, col_q};

    if (step_req[STEP_UP]) begin
      if (row_x == '0) begin
        if (WRAP != 0) row_x = ROW_MAX;
      end else begin
        row_x = row_x - ROW_ONE;
      end
    end

    if (step_req[STEP_DOWN]) begin
      if (row_x >= ROW_MAX) begin
        if (WRAP != 0) row_x = '0;
      end else begin
        row_x = row_x + ROW_ONE;
      end
    end

    if (step_req[STEP_LEFT]) begin
      if (col_x == '0) begin
        if (WRAP != 0) col_x = COL_MAX;
      end else begin
        col_x = col_x - COL_ONE;
      end
    end

    if (step_req[STEP_RIGHT]) begin
      if (col_x >= COL_MAX) begin
        if (WRAP != 0) col_x = '0;
      end else begin
        col_x = col_x + COL_ONE;
      end
    end

    row_d   = row_x[RW-1:0];
    col_d   = col_x[CW-1:0];
    idx_d   = IW'(row_d) * IW'(COLS) + IW'(col_d);
    moved_d = (row_d != row_q) || (col_d != col_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      moved_q <= 1'b0;
      sel_q   <= 1'b0;
      back_q  <= 1'b0;
    end else if (menu) begin
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      moved_q <= 1'b0;
      sel_q   <= 1'b0;
      back_q  <= 1'b0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      moved_q <= moved_d;
      sel_q   <= sel_edge;
      back_q  <= back_edge;
    end
  end

  assign bus.cur_row      = row_q;
  assign bus.cur_col      = col_q;
  assign bus.cur_index    = idx_q;
  assign bus.moved        = moved_q;
  assign bus.select_pulse = sel_q;
  assign bus.back_pulse   = back_q;

endmodule

// File: tb/tb_t07_fsm_grid_cursor.sv
module tb_t07_fsm_grid_cursor;
  import t07_fsm_grid_cursor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // A: 3x4 clamp, B: 3x4 wrap, C: 16x2 clamp (hold test), D: 1x1 wrap
  t07_fsm_grid_cursor_if #(.ROWS(3),  .COLS(4)) ia ();
  t07_fsm_grid_cursor_if #(.ROWS(3),  .COLS(4)) ib ();
  t07_fsm_grid_cursor_if #(.ROWS(16), .COLS(2)) ic ();
  t07_fsm_grid_cursor_if #(.ROWS(1),  .COLS(1)) id ();

  t07_fsm_grid_cursor #(.ROWS(3), .COLS(4), .WRAP(0), .ACTIVE_PSTATE(PS_MOD),
    .REPEAT_DLY(8), .REPEAT_RATE(3)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  t07_fsm_grid_cursor #(.ROWS(3), .COLS(4), .WRAP(1), .ACTIVE_PSTATE(PS_MOD),
    .REPEAT_DLY(8), .REPEAT_RATE(3)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
  t07_fsm_grid_cursor #(.ROWS(16), .COLS(2), .WRAP(0), .ACTIVE_PSTATE(PS_MOD),
    .REPEAT_DLY(8), .REPEAT_RATE(3)) u_c (.clk(clk), .rst(rst), .bus(ic.slave));
  t07_fsm_grid_cursor #(.ROWS(1), .COLS(1), .WRAP(1), .ACTIVE_PSTATE(PS_MOD),
    .REPEAT_DLY(8), .REPEAT_RATE(3)) u_d (.clk(clk), .rst(rst), .bus(id.slave));

  typedef struct {
    logic [2:0]  gs;
    logic [2:0]  ps;
    logic [5:0]  btn;
    logic        stb;
    logic [10:0] exp;  // {row[1:0], col[1:0], idx[3:0], moved, select, back}
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [2:0] gs, input logic [2:0] ps,
                              input logic [5:0] btn, input int stb,
                              input int row, input int col, input int idx,
                              input int mv, input int sel, input int bk);
    vec_t v;
    v.gs  = gs;
    v.ps  = ps;
    v.btn = btn;
    v.stb = stb[0];
    v.exp = {row[1:0], col[1:0], idx[3:0], mv[0], sel[0], bk[0]};
    return v;
  endfunction

  function automatic logic [10:0] a_out();
    return {ia.cur_row, ia.cur_col, ia.cur_index, ia.moved, ia.select_pulse, ia.back_pulse};
  endfunction

  function automatic logic [8:0] b_out();
    return {ib.cur_row, ib.cur_col, ib.cur_index, ib.moved};
  endfunction

  function automatic logic [13:0] c_out();
    return {ic.cur_row, ic.cur_col, ic.cur_index, ic.moved, ic.select_pulse, ic.back_pulse};
  endfunction

  function automatic logic [3:0] d_out();
    return {id.cur_row, id.cur_col, id.cur_index, id.moved};
  endfunction

  task automatic drive(input logic [2:0] gs, input logic [2:0] ps,
                       input logic [5:0] btn, input logic stb);
    ia.game_state_in = gs; ia.playing_state_in = ps; ia.button = btn; ia.strobe = stb;
    ib.game_state_in = gs; ib.playing_state_in = ps; ib.button = btn; ib.strobe = stb;
    ic.game_state_in = gs; ic.playing_state_in = ps; ic.button = btn; ic.strobe = stb;
    id.game_state_in = gs; id.playing_state_in = ps; id.button = btn; id.strobe = stb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    drive(GS_PLAY, PS_MOD, BTN_NONE, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    drive(GS_PLAY, PS_MOD, BTN_NONE, 1'b0);
    tick();
    tick();
    check("reset_a", 32'(a_out()), 32'd0);
    check("reset_b", 32'(b_out()), 32'd0);
    check("reset_c", 32'(c_out()), 32'd0);
    check("reset_d", 32'(d_out()), 32'd0);
    rst = 1'b0;

    // ---------------- table vectors on DUT A (3x4, clamp) ----------------
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_RIGHT,  1, 0,1,1, 1,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 0,1,1, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_RIGHT,  1, 0,2,2, 1,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 0,2,2, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_RIGHT,  1, 0,3,3, 1,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 0,3,3, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_RIGHT,  1, 0,3,3, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 0,3,3, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_RIGHT,  1, 0,3,3, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 0,3,3, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_DOWN,   1, 1,3,7, 1,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 1,3,7, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  6'b000110,  1, 1,3,7, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 1,3,7, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_SELECT, 1, 1,3,7, 0,1,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_SELECT, 1, 1,3,7, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_BACK,   1, 1,3,7, 0,0,1));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 1,3,7, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MAZE, BTN_SELECT, 1, 1,3,7, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MAZE, BTN_NONE,   1, 1,3,7, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MAZE, BTN_LEFT,   1, 1,3,7, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 1,3,7, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_LEFT,   0, 1,3,7, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_LEFT,   1, 1,2,6, 1,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 1,2,6, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_UP,     1, 0,2,2, 1,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 0,2,2, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_UP,     1, 0,2,2, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 0,2,2, 0,0,0));
    vq.push_back(mk(GS_LOST, PS_MOD,  BTN_RIGHT,  1, 0,2,2, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 0,2,2, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_LEFT,   1, 0,1,1, 1,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   1, 0,1,1, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_DOWN,   1, 1,1,5, 1,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_NONE,   0, 1,1,5, 0,0,0));
    vq.push_back(mk(GS_MENU, PS_MOD,  BTN_NONE,   0, 0,0,0, 0,0,0));
    vq.push_back(mk(GS_PLAY, PS_MOD,  BTN_RIGHT,  1, 0,1,1, 1,0,0));

    foreach (vq[i]) begin
      drive(vq[i].gs, vq[i].ps, vq[i].btn, vq[i].stb);
      tick();
      check($sformatf("vec%0d", i), 32'(a_out()), 32'(vq[i].exp));
    end

    // ---------------- wrap (B) and 1x1 grid (D) ----------------
    do_reset();
    drive(GS_PLAY, PS_MOD, BTN_UP, 1'b1);    tick();
    check("wrap_up_b", 32'(b_out()), 32'({2'd2, 2'd0, 4'd8, 1'b1}));
    check("one_up_d",  32'(d_out()), 32'd0);
    drive(GS_PLAY, PS_MOD, BTN_NONE, 1'b1);  tick();
    drive(GS_PLAY, PS_MOD, BTN_DOWN, 1'b1);  tick();
    check("wrap_down_b", 32'(b_out()), 32'({2'd0, 2'd0, 4'd0, 1'b1}));
    check("one_down_d",  32'(d_out()), 32'd0);
    drive(GS_PLAY, PS_MOD, BTN_NONE, 1'b1);  tick();
    drive(GS_PLAY, PS_MOD, BTN_LEFT, 1'b1);  tick();
    check("wrap_left_b", 32'(b_out()), 32'({2'd0, 2'd3, 4'd3, 1'b1}));
    check("one_left_d",  32'(d_out()), 32'd0);
    drive(GS_PLAY, PS_MOD, BTN_NONE, 1'b1);  tick();
    drive(GS_PLAY, PS_MOD, BTN_RIGHT, 1'b1); tick();
    check("wrap_right_b", 32'(b_out()), 32'({2'd0, 2'd0, 4'd0, 1'b1}));
    check("one_right_d",  32'(d_out()), 32'd0);

    // ---------------- hold DOWN 20 strobes on C (16x2) ----------------
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      drive(GS_PLAY, PS_MOD, BTN_DOWN, 1'b1);
      tick();
      check($sformatf("hold_moved_s%0d", k), 32'(ic.moved),
            32'((k == 1) || (k == 9) || (k == 12) || (k == 15) || (k == 18)));
      drive(GS_PLAY, PS_MOD, BTN_DOWN, 1'b0);
      tick();
    end
    check("hold_final_row", 32'(ic.cur_row), 32'd5);
    check("hold_final_idx", 32'(ic.cur_index), 32'd10);

    // ---------------- RIGHT held then LEFT without release on A ----------------
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      drive(GS_PLAY, PS_MOD, BTN_RIGHT, 1'b1);
      tick();
      check($sformatf("right_moved_s%0d", k), 32'(ia.moved), 32'((k == 1) || (k == 9)));
    end
    check("right_col", 32'(ia.cur_col), 32'd2);
    for (int k = 1; k <= 9; k++) begin
      drive(GS_PLAY, PS_MOD, BTN_LEFT, 1'b1);
      tick();
      check($sformatf("left_moved_s%0d", k), 32'(ia.moved), 32'((k == 1) || (k == 9)));
    end
    check("left_col", 32'(ia.cur_col), 32'd0);

    // ---------------- reset asserted mid-hold on C ----------------
    do_reset();
    drive(GS_PLAY, PS_MOD, BTN_DOWN, 1'b1);
    tick();
    check("pre_rst_c", 32'(c_out()), 32'({4'd1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0}));
    rst = 1'b1;
    #1;
    check("async_rst_c", 32'(c_out()), 32'd0);
    tick();
    check("held_rst_c", 32'(c_out()), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_edge_c", 32'({ic.cur_row, ic.moved}), 32'({4'd1, 1'b1}));
    for (int k = 2; k <= 9; k++) begin
      tick();
      check($sformatf("post_rst_moved_s%0d", k), 32'(ic.moved), 32'(k == 9));
    end
    check("post_rst_row_c", 32'(ic.cur_row), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
